// File: rtl/cam_pattern_gen_if.sv
// Camera byte-stream bundle: control inputs plus vsync/href/data and scoreboard outputs.
// The master modport is the generator side; the slave modport is the consumer/controller.
interface cam_pattern_gen_if;
    logic        i_start;
    logic        i_stop;
    logic [1:0]  i_mode;
    logic [7:0]  i_frames;
    logic [11:0] i_const;
    logic        o_vsync;
    logic        o_href;
    logic [7:0]  o_data;
    logic [11:0] o_pixel;
    logic        o_pixel_valid;
    logic        o_frame_done;
    logic        o_busy;
    logic        o_done;

    modport master (
        input  i_start, i_stop, i_mode, i_frames, i_const,
        output o_vsync, o_href, o_data, o_pixel, o_pixel_valid,
        output o_frame_done, o_busy, o_done
    );

    modport slave (
        output i_start, i_stop, i_mode, i_frames, i_const,
        input  o_vsync, o_href, o_data, o_pixel, o_pixel_valid,
        input  o_frame_done, o_busy, o_done
    );
endinterface

// File: rtl/cam_pattern_gen.sv
// Camera-style vsync/href/byte stream generator emitting RGB444 pixels as two bytes,
// with selectable test pattern and a 12-bit pixel side channel for scoreboarding.
module cam_pattern_gen #(
    parameter int          ROWCOUNT      = 10,
    parameter int          ROWLENGTH     = 20,
    parameter int          VSYNC_CYCLES  = 3,
    parameter int          VBP_CYCLES    = 17,
    parameter int          HBLANK_CYCLES = 6,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic i_clk,
    input logic i_rst,
    cam_pattern_gen_if.master bus
);
    localparam int PIX    = ROWLENGTH / 2;
    localparam int MAX_AB = (VSYNC_CYCLES > VBP_CYCLES) ? VSYNC_CYCLES : VBP_CYCLES;
    localparam int MAX_CD = (HBLANK_CYCLES > ROWLENGTH) ? HBLANK_CYCLES : ROWLENGTH;
    localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int RW     = $clog2(ROWCOUNT + 1);
    localparam int PW     = $clog2(PIX * 8);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK} state_t;

    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [RW-1:0] row_reg, row_next;
    logic [7:0]  frames_sent_reg, frames_sent_next;
    logic [7:0]  frames_reg, frames_next;
    logic [1:0]  mode_reg, mode_next;
    logic [11:0] const_reg, const_next;
    logic        stop_reg, stop_next;
    logic [11:0] count_reg, count_next;
    logic [15:0] lfsr_reg, lfsr_next;

    logic        vsync_reg, vsync_next, href_reg, href_next;
    logic [7:0]  data_reg, data_next;
    logic [11:0] pixel_reg, pixel_next;
    logic        valid_reg, valid_next, frame_done_reg, frame_done_next;
    logic        done_reg, done_next, busy_reg, busy_next;

    logic [11:0] px;
    logic [PW-1:0] prod;
    logic [2:0]  bar_idx;
    logic        fb;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        row_next         = row_reg;
        frames_sent_next = frames_sent_reg;
        frames_next      = frames_reg;
        mode_next        = mode_reg;
        const_next       = const_reg;
        stop_next        = stop_reg;
        count_next       = count_reg;
        lfsr_next        = lfsr_reg;
        fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

        if (state_reg != S_IDLE && bus.i_stop)
            stop_next = 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_next       = S_VSYNC;
                    cnt_next         = '0;
                    mode_next        = bus.i_mode;
                    frames_next      = bus.i_frames;
                    const_next       = bus.i_const;
                    stop_next        = 1'b0;
                    lfsr_next        = LFSR_SEED;
                    count_next       = '0;
                    frames_sent_next = '0;
                end
            end
            S_VSYNC: begin
                if (cnt_reg == CW'(VSYNC_CYCLES - 1)) begin
                    state_next = S_VBP;
                    cnt_next   = '0;
                end else
                    cnt_next = cnt_reg + CW'(1);
            end
            S_VBP: begin
                if (cnt_reg == CW'(VBP_CYCLES - 1)) begin
                    state_next = S_ACTIVE;
                    cnt_next   = '0;
                    row_next   = '0;
                end else
                    cnt_next = cnt_reg + CW'(1);
            end
            S_ACTIVE: begin
                if (cnt_reg == CW'(ROWLENGTH - 1)) begin
                    state_next = S_HBLANK;
                    cnt_next   = '0;
                end else
                    cnt_next = cnt_reg + CW'(1);
            end
            S_HBLANK: begin
                if (cnt_reg == CW'(HBLANK_CYCLES - 1)) begin
                    cnt_next = '0;
                    if (row_reg != RW'(ROWCOUNT - 1)) begin
                        row_next   = row_reg + RW'(1);
                        state_next = S_ACTIVE;
                    end else begin
                        frames_sent_next = frames_sent_reg + 8'd1;
                        if (stop_reg || (frames_reg != 8'd0 && frames_sent_next == frames_reg))
                            state_next = S_IDLE;
                        else begin
                            state_next = S_VSYNC;
                            count_next = '0;
                        end
                    end
                end else
                    cnt_next = cnt_reg + CW'(1);
            end
            default: state_next = S_IDLE;
        endcase

        // Pattern state steps at the edge that launches each odd (low) byte.
        if (state_next == S_ACTIVE && cnt_next[0]) begin
            count_next = count_reg + 12'd1;
            lfsr_next  = {lfsr_reg[14:0], fb};
        end

        prod    = PW'(cnt_next >> 1) << 3;
        bar_idx = 3'(prod / PW'(PIX));
        case (mode_reg)
            2'd0:    px = count_reg;
            2'd1:    px = lfsr_reg[11:0];
            2'd2:    px = bar_colour(bar_idx);
            default: px = const_reg;
        endcase

        vsync_next = (state_next == S_VSYNC);
        href_next  = (state_next == S_ACTIVE);
        data_next  = '0;
        pixel_next = '0;
        valid_next = 1'b0;
        if (href_next) begin
            if (cnt_next[0]) begin
                data_next  = px[7:0];
                pixel_next = px;
                valid_next = 1'b1;
            end else
                data_next = {4'hF, px[11:8]};
        end
        frame_done_next = (state_next == S_HBLANK) && (cnt_next == CW'(HBLANK_CYCLES - 1)) &&
                          (row_next == RW'(ROWCOUNT - 1));
        done_next = frame_done_next &&
                    (stop_next || (frames_next != 8'd0 && 8'(frames_sent_next + 8'd1) == frames_next));
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            row_reg         <= '0;
            frames_sent_reg <= '0;
            frames_reg      <= '0;
            mode_reg        <= '0;
            const_reg       <= '0;
            stop_reg        <= 1'b0;
            count_reg       <= '0;
            lfsr_reg        <= '0;
            vsync_reg       <= 1'b0;
            href_reg        <= 1'b0;
            data_reg        <= '0;
            pixel_reg       <= '0;
            valid_reg       <= 1'b0;
            frame_done_reg  <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            row_reg         <= row_next;
            frames_sent_reg <= frames_sent_next;
            frames_reg      <= frames_next;
            mode_reg        <= mode_next;
            const_reg       <= const_next;
            stop_reg        <= stop_next;
            count_reg       <= count_next;
            lfsr_reg        <= lfsr_next;
            vsync_reg       <= vsync_next;
            href_reg        <= href_next;
            data_reg        <= data_next;
            pixel_reg       <= pixel_next;
            valid_reg       <= valid_next;
            frame_done_reg  <= frame_done_next;
            done_reg        <= done_next;
            busy_reg        <= busy_next;
        end
    end

    assign bus.o_vsync       = vsync_reg;
    assign bus.o_href        = href_reg;
    assign bus.o_data        = data_reg;
    assign bus.o_pixel       = pixel_reg;
    assign bus.o_pixel_valid = valid_reg;
    assign bus.o_frame_done  = frame_done_reg;
    assign bus.o_done        = done_reg;
    assign bus.o_busy        = busy_reg;
endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: a frame-timing model derived from the geometry checks every
// cycle of three differently sized generators, plus literal pins at key cycles.
module tb_cam_pattern_gen;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cam_pattern_gen_if bus0();
    cam_pattern_gen_if bus1();
    cam_pattern_gen_if bus2();

    cam_pattern_gen dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    cam_pattern_gen #(.ROWCOUNT(2), .ROWLENGTH(32)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    cam_pattern_gen #(.ROWCOUNT(64), .ROWLENGTH(130), .VSYNC_CYCLES(1), .VBP_CYCLES(1),
                      .HBLANK_CYCLES(1)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    // {vsync, href, data[7:0], pixel[11:0], valid, frame_done, done, busy}
    logic [25:0] act [3];
    assign act[0] = {bus0.o_vsync, bus0.o_href, bus0.o_data, bus0.o_pixel, bus0.o_pixel_valid,
                     bus0.o_frame_done, bus0.o_done, bus0.o_busy};
    assign act[1] = {bus1.o_vsync, bus1.o_href, bus1.o_data, bus1.o_pixel, bus1.o_pixel_valid,
                     bus1.o_frame_done, bus1.o_done, bus1.o_busy};
    assign act[2] = {bus2.o_vsync, bus2.o_href, bus2.o_data, bus2.o_pixel, bus2.o_pixel_valid,
                     bus2.o_frame_done, bus2.o_done, bus2.o_busy};

    typedef struct {
        int active; int n; int mode; int cnst; int nframes;
        int rc; int rl; int vs; int vb; int hb;
    } run_t;
    run_t runs [3];
    logic [15:0] lfsr_tab [0:511];

    function automatic logic [11:0] bar_rgb(input int bar);
        case (bar)
            0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
            4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
        endcase
    endfunction

    // Expected outputs at cycle c from cycles elapsed since the accepted start.
    function automatic logic [25:0] model_out(input run_t m, input int c);
        int t, fp, rp, pix, f, r, row, b, idx;
        logic [11:0] px;
        logic [25:0] o;
        o = '0;
        if (m.active == 0) return o;
        rp = m.rl + m.hb;
        fp = m.vs + m.vb + m.rc * rp;
        pix = m.rl / 2;
        t = c - m.n - 1;
        if (t < 0 || t >= m.nframes * fp) return o;
        f = t / fp;
        r = t % fp;
        o[0] = 1'b1;
        if (r == fp - 1) begin
            o[2] = 1'b1;
            o[1] = (f == m.nframes - 1);
        end
        if (r < m.vs) o[25] = 1'b1;
        else if (r >= m.vs + m.vb) begin
            row = (r - m.vs - m.vb) / rp;
            b   = (r - m.vs - m.vb) % rp;
            if (b < m.rl) begin
                o[24] = 1'b1;
                idx = row * pix + b / 2;
                case (m.mode)
                    0:       px = 12'(idx);
                    1:       px = lfsr_tab[f * m.rc * pix + idx][11:0];
                    2:       px = bar_rgb(((b / 2) * 8) / pix);
                    default: px = 12'(m.cnst);
                endcase
                if (b % 2 == 1) begin
                    o[23:16] = px[7:0];
                    o[15:4]  = px;
                    o[3]     = 1'b1;
                end else
                    o[23:16] = {4'hF, px[11:8]};
            end
        end
        return o;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [25:0] e;
            e = model_out(runs[i], cyc);
            total++;
            if (act[i] !== e) begin
                bad++;
                $display("FAIL stream dut%0d cyc=%0d got=%h expected=%h", i, cyc, act[i], e);
            end
        end
    end

    task automatic lit(input string nm, input logic [25:0] a, input logic [25:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, a, e);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int id, input logic st, input logic sp, input int mode,
                         input int frames, input int cnst);
        case (id)
            0: begin bus0.i_start = st; bus0.i_stop = sp; bus0.i_mode = 2'(mode);
                     bus0.i_frames = 8'(frames); bus0.i_const = 12'(cnst); end
            1: begin bus1.i_start = st; bus1.i_stop = sp; bus1.i_mode = 2'(mode);
                     bus1.i_frames = 8'(frames); bus1.i_const = 12'(cnst); end
            default: begin bus2.i_start = st; bus2.i_stop = sp; bus2.i_mode = 2'(mode);
                     bus2.i_frames = 8'(frames); bus2.i_const = 12'(cnst); end
        endcase
    endtask

    task automatic start_run(input int id, input int mode, input int frames, input int cnst,
                             input int nf_model, output int n);
        n = cyc;
        runs[id].active = 1; runs[id].n = n; runs[id].mode = mode;
        runs[id].cnst = cnst; runs[id].nframes = nf_model;
        $display("start dut%0d mode=%0d frames=%0d const=%h at cycle %0d", id, mode, frames, cnst, n);
        drive(id, 1'b1, 1'b0, mode, frames, cnst);
        @(posedge clk);
        #1;
        drive(id, 1'b0, 1'b0, mode, frames, cnst);
    endtask

    int n, t_stop;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 0, 0, 0);
        lfsr_tab[0] = 16'hACE1;
        for (int i = 1; i < 512; i++)
            lfsr_tab[i] = {lfsr_tab[i-1][14:0],
                           lfsr_tab[i-1][15] ^ lfsr_tab[i-1][13] ^ lfsr_tab[i-1][12] ^ lfsr_tab[i-1][10]};
        runs[0] = '{0, 0, 0, 0, 0, 10, 20, 3, 17, 6};
        runs[1] = '{0, 0, 0, 0, 0, 2, 32, 3, 17, 6};
        runs[2] = '{0, 0, 0, 0, 0, 64, 130, 1, 1, 1};
        repeat (3) @(posedge clk);
        #1;
        lit("reset_outputs", act[0], 26'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Defaults, counter pattern, one frame
        start_run(0, 0, 1, 0, 1, n);
        wait_cyc(n + 3);   lit("vsync_high", act[0][25], 1);
        wait_cyc(n + 4);   lit("vsync_low", act[0][25], 0);
        wait_cyc(n + 20);  lit("href_before", act[0][24], 0);
        wait_cyc(n + 21);  lit("href_first", act[0][24], 1);  lit("byte0", act[0][23:16], 8'hF0);
        wait_cyc(n + 22);  lit("byte1", act[0][23:16], 8'h00); lit("pix0_valid", act[0][3], 1);
        wait_cyc(n + 24);  lit("byte3", act[0][23:16], 8'h01);
        wait_cyc(n + 280); lit("done_m0", act[0][1], 1);    lit("fdone_m0", act[0][2], 1);
        wait_cyc(n + 281); lit("busy_after", act[0][0], 0);

        // LFSR, two frames, started in the first idle cycle; a start while busy is ignored
        start_run(0, 1, 2, 0, 2, n);
        wait_cyc(n + 22);  lit("lfsr_pix0", act[0][15:4], 12'hCE1);
        wait_cyc(n + 24);  lit("lfsr_pix1", act[0][15:4], 12'h9C3);
        wait_cyc(n + 50);
        drive(0, 1'b1, 1'b0, 3, 7, 12'h123);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        wait_cyc(n + 560); lit("done_lfsr", act[0][1], 1);
        wait_cyc(n + 561);

        // Constant, free-run, stop mid-row 3 of frame 4
        start_run(0, 3, 0, 12'hA5C, 1000, n);
        wait_cyc(n + 21);  lit("const_hi", act[0][23:16], 8'hFA);
        wait_cyc(n + 22);  lit("const_lo", act[0][23:16], 8'h5C);
        t_stop = 3 * 280 + 20 + 3 * 26 + 5;
        wait_cyc(n + 1 + t_stop);
        runs[0].nframes = t_stop / 280 + 1;
        drive(0, 1'b0, 1'b1, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        wait_cyc(n + 1120); lit("done_stop", act[0][1], 1);
        wait_cyc(n + 1122); lit("no_frame5", act[0][25], 0);

        // Asynchronous reset during ACTIVE
        start_run(0, 0, 1, 0, 1, n);
        wait_cyc(n + 30);
        lit("pre_reset_href", act[0][24], 1);
        #2;
        rst = 1'b1;
        runs[0].active = 0;
        #1;
        lit("reset_midframe", act[0], 26'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        start_run(0, 0, 1, 0, 1, n);
        wait_cyc(n + 10);
        drive(0, 1'b1, 1'b0, 2, 5, 0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        wait_cyc(n + 22);  lit("post_reset_pix0", act[0][15:4], 12'h000);
        wait_cyc(n + 280); lit("done_post_reset", act[0][1], 1);
        wait_cyc(n + 282);

        // Colour bars, 16 pixels per row
        start_run(1, 2, 1, 0, 1, n);
        wait_cyc(n + 22);  lit("bar_pix0", act[1][15:4], 12'hFFF);
        wait_cyc(n + 26);  lit("bar_pix2", act[1][15:4], 12'hFF0);
        wait_cyc(n + 51);  lit("bar_byte30", act[1][23:16], 8'hF0);
        wait_cyc(n + 52);  lit("bar_pix15", act[1][15:4], 12'h000);
        wait_cyc(n + 96);  lit("done_bars", act[1][1], 1);

        // Counter wrap across 4160 pixels
        start_run(2, 0, 1, 0, 1, n);
        wait_cyc(n + 8257); lit("wrap_fff", act[2][15:4], 12'hFFF);
        wait_cyc(n + 8259); lit("wrap_000", act[2][15:4], 12'h000); lit("wrap_valid", act[2][3], 1);
        wait_cyc(n + 8386); lit("done_wrap", act[2][1], 1);
        wait_cyc(n + 8390);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cam_pattern_gen.md
# cam_pattern_gen

Synthesizable camera-interface stimulus generator that drives the same vsync/href/8-bit byte stream as the camera into `capture`. It emits RGB444 pixels as two bytes each, with a configurable frame geometry, blanking, pixel pattern and frame count. It replaces the behavioural frame/row loops in the system bench, can sit in front of `capture` on hardware for camera-less bring-up, and exports the expected 12-bit pixel stream for scoreboarding.

## Interface
- `ROWCOUNT`, default 10: active rows per frame (≥1).
- `ROWLENGTH`, default 20: bytes per row. Must be even; pixels per row PIX = ROWLENGTH/2.
- `VSYNC_CYCLES`, default 3: vsync high width in clocks (≥1).
- `VBP_CYCLES`, default 17: vsync back porch, vsync low before the first href (≥1).
- `HBLANK_CYCLES`, default 6: href low cycles after each row (≥1).
- `LFSR_SEED`, default 16'hACE1: LFSR seed, must be nonzero.
- `i_clk`, in, 1: pixel clock. This is the single clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: single-cycle start request. Ignored while `o_busy`.
- `i_stop`, in, 1: finish the current frame, then go idle. The stop request is sticky until idle.
- `i_mode`, in, 2: pattern select. 0 = counter, 1 = LFSR, 2 = colour bars, 3 = constant. Sampled at `i_start` only.
- `i_frames`, in, 8: number of frames to send. 0 = free-run until stop. Sampled at `i_start`.
- `i_const`, in, 12: pixel value for mode 3. Sampled at `i_start`.
- `o_vsync`, out, 1: camera vsync.
- `o_href`, out, 1: camera href.
- `o_data`, out, 8: camera data byte.
- `o_pixel`, out, 12: expected RGB444 pixel, for the scoreboard.
- `o_pixel_valid`, out, 1: `o_pixel` is valid this cycle.
- `o_frame_done`, out, 1: one-cycle pulse at the end of each frame.
- `o_busy`, out, 1: high from the cycle after an accepted start until return to IDLE.
- `o_done`, out, 1: one-cycle pulse when the run completes (count reached or stopped).

## Operation
- **FSM states:** IDLE, VSYNC, VBP, ACTIVE, HBLANK.
- **IDLE:** `i_start` moves to VSYNC. The FSM latches mode, frame count and constant, clears the stop flag, and reseeds the LFSR.
- **VSYNC:** `o_vsync`=1 for VSYNC_CYCLES, then the FSM moves to VBP.
- **VBP:** `o_vsync`=0 for VBP_CYCLES, then the FSM moves to ACTIVE with row=0.
- **ACTIVE:** `o_href`=1 for ROWLENGTH cycles; byte index b runs 0..ROWLENGTH-1.
  - Even b: `o_data`={4'hF, px[11:8]}.
  - Odd b: `o_data`=px[7:0], `o_pixel`=px, `o_pixel_valid`=1.
  - The pattern advances after each odd byte.
- **HBLANK:** `o_href`=0 and `o_data`=0 for HBLANK_CYCLES.
  - If row < ROWCOUNT-1: increment row and go to ACTIVE.
  - Else: pulse `o_frame_done` and increment the frame counter. Then:
    - If (stop flag) or (`i_frames`≠0 and frames sent == `i_frames`): go to IDLE and pulse `o_done` in the same cycle as `o_frame_done`.
    - Otherwise go to VSYNC.
- **Pixel patterns** (col = pixel index within the row, 0..PIX-1):
  - Mode 0 (counter): a 12-bit count, cleared on entry to VSYNC, +1 per pixel, wraps 4095→0.
  - Mode 1 (LFSR): px = lfsr[11:0]. The LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11 (shift left, feedback into bit 0). It is stepped once per pixel and reseeded only at `i_start`, so successive frames differ.
  - Mode 2 (colour bars): bar = (col*8)/PIX. Colours by bar 0..7: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Mode 3 (constant): px = latched `i_const`.
- **Arithmetic:**
  - Counters are sized with `$clog2(max+1)`.
  - The colour-bar product uses width `$clog2(PIX*8)`; there is no truncation before the divide.
  - The divide is by a constant and is elaborated as such.
- **Stop:** `i_stop` in any non-IDLE state sets the stop flag. The current frame always completes. A stop in IDLE is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE and all counters and flags clear. Reset asserted mid-frame forces all outputs to 0 asynchronously.
- With `i_start` high in cycle N (IDLE):
  - `o_busy` and `o_vsync` are 1 from N+1; `o_vsync` falls at N+1+VSYNC_CYCLES.
  - `o_href` rises at N+1+VSYNC_CYCLES+VBP_CYCLES.
- Row period = ROWLENGTH+HBLANK_CYCLES. Frame period = VSYNC_CYCLES + VBP_CYCLES + ROWCOUNT*(ROWLENGTH+HBLANK_CYCLES).
- `o_frame_done` and `o_done` fire in the last HBLANK cycle. `o_busy` is 0 the next cycle. A new `i_start` is accepted in that first IDLE cycle.
- `i_start` and `i_stop` in the same IDLE cycle: start is accepted, stop is ignored.

## Test plan
- **Defaults, mode 0, `i_frames`=1, start at N:**
  - vsync high N+1..N+3; href first high at N+21.
  - 10 rows of 20 href cycles each.
  - Pixels 000,001,…,063 with first row bytes F0,00,F0,01…
  - `o_done` at N+280, with `o_frame_done` in the same cycle.
- **Mode 2, ROWLENGTH=32 (PIX=16):**
  - Each row is pixels FFF×2, FF0×2, 0FF×2, 0F0×2, F0F×2, F00×2, 00F×2, 000×2.
  - Every even byte has upper nibble F.
- **Mode 1, `i_frames`=2:** pixel 0 = ACE1[11:0]=0xCE1. Frame 2 continues the sequence without repeating. A bench model of the LFSR matches all 200 pixels.
- **Mode 3, `i_const`=0xA5C, `i_frames`=0 (free-run):**
  - Every pixel is A5C (bytes FA, 5C).
  - `i_stop` pulsed mid-row 3 of frame 4: frame 4 completes, `o_done` follows, and no frame 5 vsync appears.
- **Reset and start handling:**
  - Assert `i_rst` during ACTIVE: all outputs 0 immediately and state is IDLE.
  - After deassert, `i_start` while busy is ignored.
  - A start in the first IDLE cycle after `o_done` is accepted.
- **Counter wrap:** mode 0 with ROWCOUNT=64, ROWLENGTH=130 (4160 pixels): pixel 4095=FFF is followed by 000.
